il_run_ctrl: RTL and testbench

Host-side run controller driving the interruption-logic clock gate. Accepts run/reset/read/halt commands over a valid/ready channel from the debug bridge. Drives the gate's reset, clock-enable and breakpoint inputs. Tracks an internal mirror of the gate's cycle counter to detect the breakpoint, then returns one response word per command carrying the design's `count_out`.

---
 rtl/il_run_ctrl_if.sv | 24 ++
 rtl/il_run_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_il_run_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/il_run_ctrl_if.sv
// Command/response channel between the debug bridge and the run controller.
// The bridge is the master: it issues commands and consumes responses.
interface il_run_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_arg;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_code;
  logic [CNT_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_code, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, rsp_ready,
    output cmd_ready, rsp_valid, rsp_code, rsp_data
  );
endinterface

// File: rtl/il_run_ctrl.sv
// Host-side run controller for the interruption-logic clock gate.
// Pulses the gate reset, runs the gate up to a breakpoint while tracking
// its cycle counter in a local mirror, and answers every command with
// exactly one response word.
module il_run_ctrl #(
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 4
) (
  input  logic             sys_clk,
  input  logic             sys_reset_n,
  il_run_ctrl_if.slave     bus,
  output logic             il_reset,
  output logic             il_clk_en,
  output logic [CNT_W-1:0] il_breakpoint,
  input  logic [CNT_W-1:0] il_count
);

  localparam int PC_W = $clog2(RST_CYCLES + 1);
  localparam logic [PC_W-1:0] PULSE_LOAD = PC_W'(RST_CYCLES);

  localparam logic [1:0] OP_RESET  = 2'd0;
  localparam logic [1:0] OP_RUN_TO = 2'd1;
  localparam logic [1:0] OP_READ   = 2'd2;
  localparam logic [1:0] OP_HALT   = 2'd3;

  localparam logic [1:0] RC_OK     = 2'd0;
  localparam logic [1:0] RC_ERR    = 2'd1;
  localparam logic [1:0] RC_HALTED = 2'd2;

  typedef enum logic [1:0] {RST, IDLE, RUN, RESP} state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pulse_cnt, pulse_cnt_nxt;
  logic             from_cmd, from_cmd_nxt;
  logic             il_reset_nxt, il_clk_en_nxt;
  logic [CNT_W-1:0] il_breakpoint_nxt;
  logic [CNT_W-1:0] mirror, mirror_nxt;
  logic             rsp_valid, rsp_valid_nxt;
  logic [1:0]       rsp_code, rsp_code_nxt;
  logic [CNT_W-1:0] rsp_data, rsp_data_nxt;
  logic             cmd_ready;

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_code  = rsp_code;
  assign bus.rsp_data  = rsp_data;

  // Next-state and next-output decode; everything holds unless a branch says otherwise.
  always_comb begin
    state_nxt         = state;
    pulse_cnt_nxt     = pulse_cnt;
    from_cmd_nxt      = from_cmd;
    il_reset_nxt      = il_reset;
    il_clk_en_nxt     = il_clk_en;
    il_breakpoint_nxt = il_breakpoint;
    mirror_nxt        = mirror;
    rsp_valid_nxt     = rsp_valid;
    rsp_code_nxt      = rsp_code;
    rsp_data_nxt      = rsp_data;
    cmd_ready         = 1'b0;

    case (state)
      RST: begin
        il_clk_en_nxt     = 1'b0;
        mirror_nxt        = '0;
        il_breakpoint_nxt = '0;
        if (pulse_cnt <= PC_W'(1)) begin
          il_reset_nxt = 1'b0;
          from_cmd_nxt = 1'b0;
          if (from_cmd) begin
            state_nxt     = RESP;
            rsp_valid_nxt = 1'b1;
            rsp_code_nxt  = RC_OK;
            rsp_data_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          pulse_cnt_nxt = pulse_cnt - PC_W'(1);
        end
      end

      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_RESET: begin
              state_nxt         = RST;
              il_reset_nxt      = 1'b1;
              pulse_cnt_nxt     = PULSE_LOAD;
              from_cmd_nxt      = 1'b1;
              mirror_nxt        = '0;
              il_breakpoint_nxt = '0;
            end
            OP_READ: begin
              state_nxt     = RESP;
              rsp_valid_nxt = 1'b1;
              rsp_code_nxt  = RC_OK;
              rsp_data_nxt  = il_count;
            end
            OP_HALT: begin
              state_nxt     = RESP;
              rsp_valid_nxt = 1'b1;
              rsp_code_nxt  = RC_OK;
              rsp_data_nxt  = mirror;
            end
            default: begin
              // RUN_TO: refuse to go backwards, answer at once when already there.
              if (bus.cmd_arg < mirror) begin
                state_nxt     = RESP;
                rsp_valid_nxt = 1'b1;
                rsp_code_nxt  = RC_ERR;
                rsp_data_nxt  = mirror;
              end else if (bus.cmd_arg == mirror) begin
                state_nxt     = RESP;
                rsp_valid_nxt = 1'b1;
                rsp_code_nxt  = RC_OK;
                rsp_data_nxt  = il_count;
              end else begin
                state_nxt         = RUN;
                il_breakpoint_nxt = bus.cmd_arg;
                il_clk_en_nxt     = 1'b1;
              end
            end
          endcase
        end
      end

      RUN: begin
        // Only HALT may interrupt a run; it wins over a same-cycle breakpoint hit.
        cmd_ready = bus.cmd_valid & (bus.cmd_op == OP_HALT);
        if (cmd_ready) begin
          il_clk_en_nxt = 1'b0;
          state_nxt     = RESP;
          rsp_valid_nxt = 1'b1;
          rsp_code_nxt  = RC_HALTED;
          rsp_data_nxt  = mirror;
        end else if (mirror == il_breakpoint) begin
          il_clk_en_nxt = 1'b0;
          state_nxt     = RESP;
          rsp_valid_nxt = 1'b1;
          rsp_code_nxt  = RC_OK;
          rsp_data_nxt  = il_count;
        end else begin
          mirror_nxt = mirror + CNT_W'(1);
        end
      end

      default: begin
        if (bus.rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
    endcase
  end

  // State and registered outputs; async reset forces the gate back into reset.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state         <= RST;
      pulse_cnt     <= PULSE_LOAD;
      from_cmd      <= 1'b0;
      il_reset      <= 1'b1;
      il_clk_en     <= 1'b0;
      il_breakpoint <= '0;
      mirror        <= '0;
      rsp_valid     <= 1'b0;
      rsp_code      <= RC_OK;
      rsp_data      <= '0;
    end else begin
      state         <= state_nxt;
      pulse_cnt     <= pulse_cnt_nxt;
      from_cmd      <= from_cmd_nxt;
      il_reset      <= il_reset_nxt;
      il_clk_en     <= il_clk_en_nxt;
      il_breakpoint <= il_breakpoint_nxt;
      mirror        <= mirror_nxt;
      rsp_valid     <= rsp_valid_nxt;
      rsp_code      <= rsp_code_nxt;
      rsp_data      <= rsp_data_nxt;
    end
  end

endmodule

// File: tb/tb_il_run_ctrl.sv
// Directed bench for il_run_ctrl. A small clock-gate model supplies il_count
// (offset so gate-derived data differs from mirror-derived data); expected
// responses are queued at issue time and checked by an independent monitor.
module tb_il_run_ctrl;
  localparam int W = 32;
  localparam logic [W-1:0] OFS = 32'h0000_1000;

  localparam logic [1:0] OP_RESET = 2'd0, OP_RUN_TO = 2'd1, OP_READ = 2'd2, OP_HALT = 2'd3;
  localparam logic [1:0] RC_OK = 2'd0, RC_ERR = 2'd1, RC_HALTED = 2'd2;

  logic         sys_clk = 1'b0;
  logic         sys_reset_n = 1'b0;
  logic         il_reset, il_clk_en;
  logic [W-1:0] il_breakpoint, il_count, gate;

  typedef struct packed {
    logic [1:0]   code;
    logic [W-1:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  il_run_ctrl_if #(.CNT_W(W)) bus ();

  il_run_ctrl #(.CNT_W(W), .RST_CYCLES(4)) dut (
    .sys_clk       (sys_clk),
    .sys_reset_n   (sys_reset_n),
    .bus           (bus),
    .il_reset      (il_reset),
    .il_clk_en     (il_clk_en),
    .il_breakpoint (il_breakpoint),
    .il_count      (il_count)
  );

  always #5 sys_clk = ~sys_clk;

  // Clock-gate model: counts enabled cycles and stops at its breakpoint.
  always @(posedge sys_clk) begin
    if (il_reset) gate <= '0;
    else if (il_clk_en && gate != il_breakpoint) gate <= gate + 32'd1;
  end
  assign il_count = gate + OFS;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_rsp(input logic [1:0] code, input logic [W-1:0] data);
    rsp_t e;
    e.code = code;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Response monitor: compare each handshaken response with the queue head.
  always @(negedge sys_clk) begin : monitor
    rsp_t e;
    if (sys_reset_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: actual code=%0d data=%0h required no response",
                 bus.rsp_code, bus.rsp_data);
      end else begin
        e = exp_q.pop_front();
        check("rsp_code", W'(bus.rsp_code), W'(e.code));
        check("rsp_data", bus.rsp_data, e.data);
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [W-1:0] arg);
    bit acc = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (bus.cmd_ready) begin
        acc = 1;
        break;
      end
    end
    @(posedge sys_clk);
    #1;
    bus.cmd_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: actual=not accepted required=accepted op=%0d", op);
    end
  endtask

  // Counts enabled cycles until the response appears, then lets it be consumed.
  task automatic run_count(output int n);
    bit seen = 0;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      if (bus.rsp_valid) begin
        seen = 1;
        break;
      end
      if (il_clk_en) n++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: actual=no rsp_valid required=rsp_valid");
    end
    @(posedge sys_clk);
    #1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_arg   = '0;
    bus.rsp_ready = 1'b1;

    // Held in reset.
    repeat (2) @(negedge sys_clk);
    check("rst_il_reset", W'(il_reset), 32'd1);
    check("rst_clk_en", W'(il_clk_en), 32'd0);
    check("rst_rsp_valid", W'(bus.rsp_valid), 32'd0);
    check("rst_breakpoint", il_breakpoint, 32'd0);
    check("rst_cmd_ready", W'(bus.cmd_ready), 32'd0);

    // Release: il_reset high four cycles, then IDLE with cmd_ready.
    sys_reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge sys_clk);
      check("boot_il_reset", W'(il_reset), (k < 4) ? 32'd1 : 32'd0);
      check("boot_cmd_ready", W'(bus.cmd_ready), (k == 4) ? 32'd1 : 32'd0);
      check("boot_rsp_valid", W'(bus.rsp_valid), 32'd0);
    end
    @(posedge sys_clk); #1;

    // RUN_TO 10 from 0: 11 enabled cycles.
    expect_rsp(RC_OK, OFS + 32'd10);
    send(OP_RUN_TO, 32'd10);
    run_count(n);
    check("run10_en_cycles", W'(n), 32'd11);
    check("run10_breakpoint", il_breakpoint, 32'd10);

    // Backwards target: error with mirror, no enable.
    expect_rsp(RC_ERR, 32'd10);
    send(OP_RUN_TO, 32'd5);
    run_count(n);
    check("run5_err_en_cycles", W'(n), 32'd0);

    // Target equals mirror: immediate OK with gate count.
    expect_rsp(RC_OK, OFS + 32'd10);
    send(OP_RUN_TO, 32'd10);
    run_count(n);
    check("run_eq_en_cycles", W'(n), 32'd0);

    // RUN_TO 12 from 10: 3 enabled cycles.
    expect_rsp(RC_OK, OFS + 32'd12);
    send(OP_RUN_TO, 32'd12);
    run_count(n);
    check("run12_en_cycles", W'(n), 32'd3);

    expect_rsp(RC_OK, OFS + 32'd12);
    send(OP_READ, '0);
    run_count(n);

    expect_rsp(RC_OK, 32'd12);
    send(OP_HALT, '0);
    run_count(n);

    // RESET command: four cycles of il_reset, then OK/0.
    expect_rsp(RC_OK, 32'd0);
    send(OP_RESET, '0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge sys_clk);
      check("rstcmd_il_reset", W'(il_reset), (k < 5) ? 32'd1 : 32'd0);
      check("rstcmd_rsp_valid", W'(bus.rsp_valid), (k == 5) ? 32'd1 : 32'd0);
    end
    check("rstcmd_breakpoint", il_breakpoint, 32'd0);
    @(posedge sys_clk); #1;

    expect_rsp(RC_OK, 32'd0);
    send(OP_HALT, '0);
    run_count(n);

    // RUN_TO 1000; READ held off during RUN; HALT after 20 increments.
    expect_rsp(RC_HALTED, 32'd20);
    send(OP_RUN_TO, 32'd1000);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_READ;
    bus.cmd_arg   = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      check("run_read_held", W'({bus.cmd_ready, il_clk_en}), 32'd1);
      @(posedge sys_clk);
    end
    #1;
    bus.rsp_ready = 1'b0;
    bus.cmd_op    = OP_HALT;
    @(negedge sys_clk);
    check("halt_ready", W'(bus.cmd_ready), 32'd1);
    @(posedge sys_clk); #1;
    bus.cmd_op = OP_READ;
    expect_rsp(RC_OK, OFS + 32'd21);
    for (int i = 0; i < 7; i++) begin
      @(negedge sys_clk);
      check("stall_ctl", W'({bus.rsp_valid, bus.rsp_code, bus.cmd_ready, il_clk_en}),
            W'({1'b1, RC_HALTED, 1'b0, 1'b0}));
      check("stall_data", bus.rsp_data, 32'd20);
      @(posedge sys_clk);
    end
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge sys_clk);
    check("rsp_release_cmd_ready", W'(bus.cmd_ready), 32'd0);
    @(negedge sys_clk);
    check("read_after_rsp_ready", W'(bus.cmd_ready), 32'd1);
    @(posedge sys_clk); #1;
    bus.cmd_valid = 1'b0;
    run_count(n);

    // Async reset in the middle of a run: drop everything, no response.
    send(OP_RUN_TO, 32'd100);
    repeat (5) begin
      @(posedge sys_clk);
    end
    #1;
    check("pre_areset_clk_en", W'(il_clk_en), 32'd1);
    sys_reset_n = 1'b0;
    #1;
    check("areset_clk_en", W'(il_clk_en), 32'd0);
    check("areset_il_reset", W'(il_reset), 32'd1);
    check("areset_rsp_valid", W'(bus.rsp_valid), 32'd0);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    check("areset_idle_ready", W'(bus.cmd_ready), 32'd1);
    check("areset_breakpoint", il_breakpoint, 32'd0);
    @(posedge sys_clk); #1;

    expect_rsp(RC_OK, 32'd0);
    send(OP_HALT, '0);
    run_count(n);

    expect_rsp(RC_OK, OFS + 32'd3);
    send(OP_RUN_TO, 32'd3);
    run_count(n);
    check("run3_en_cycles", W'(n), 32'd4);

    repeat (3) begin
      @(posedge sys_clk);
    end
    #1;
    check("queue_drained", W'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
